// File: rtl/button_bank_pkg.sv
// button_bank_pkg
//   Shared definitions for the button_bank slice: the per-channel FSM state
//   encoding, a constant clog2 helper, and the counter-width derivation used
//   by every channel instance.
package button_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_LONG     = 2'd3
  } btn_state_t;

  // Smallest r such that 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width able to hold max(long_cycles, repeat_cycles) inclusive.
  function automatic int unsigned ctr_width(input int unsigned long_cycles,
                                            input int unsigned repeat_cycles);
    longint unsigned m;
    int unsigned w;
    m = (long_cycles > repeat_cycles) ? 64'(long_cycles) : 64'(repeat_cycles);
    w = clog2(m + 64'd1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_bank_chan.sv
// button_bank_chan
//   One button channel: 2-flop synchroniser, saturating hold counter,
//   repeat counter and IDLE/DEBOUNCE/HELD/LONG state machine. All outputs
//   are registered.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   btn   - raw asynchronous button input
//   held  - debounced pressed level
//   press - one-cycle pulse when a short press is released
//   long  - one-cycle pulse when the hold reaches LONG_CYCLES
//   rpt   - one-cycle auto-repeat pulse while held past the long threshold
module button_bank_chan
  import button_bank_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW      = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 262144,
  parameter int unsigned LONG_CYCLES     = 67108863,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_CYCLES   = 8388608
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic held,
  output logic press,
  output logic long,
  output logic rpt
);

  localparam int unsigned CW = ctr_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_V  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG_V = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] REP_V  = CW'(REPEAT_CYCLES);
  localparam logic INACT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [1:0]    sync_q;
  logic [CW-1:0] ctr;
  logic [CW-1:0] rc;
  btn_state_t    state;

  logic          s;
  logic [CW-1:0] ctr_n;
  logic [CW-1:0] rc_n;

  // Decisions use the post-increment count so that the threshold sample and
  // the output update land on the same edge.
  always_comb begin
    s     = sync_q[1] ^ INACT;
    ctr_n = '0;
    if (s) ctr_n = (ctr == LONG_V) ? LONG_V : ctr + 1'b1;
    rc_n  = rc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{INACT}};
      ctr    <= '0;
      rc     <= '0;
      state  <= ST_IDLE;
      held   <= 1'b0;
      press  <= 1'b0;
      long   <= 1'b0;
      rpt    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      ctr    <= ctr_n;
      press  <= 1'b0;
      long   <= 1'b0;
      rpt    <= 1'b0;
      case (state)
        ST_IDLE, ST_DEBOUNCE: begin
          if (!s) begin
            state <= ST_IDLE;
          end else if (ctr_n >= DEB_V) begin
            state <= ST_HELD;
            held  <= 1'b1;
          end else begin
            state <= ST_DEBOUNCE;
          end
        end
        ST_HELD: begin
          if (!s) begin
            state <= ST_IDLE;
            held  <= 1'b0;
            press <= 1'b1;
          end else if (ctr_n == LONG_V) begin
            state <= ST_LONG;
            long  <= 1'b1;
            rc    <= '0;
          end
        end
        ST_LONG: begin
          if (!s) begin
            state <= ST_IDLE;
            held  <= 1'b0;
          end else if (REPEAT_EN != 0) begin
            if (rc_n == REP_V) begin
              rpt <= 1'b1;
              rc  <= '0;
            end else begin
              rc <= rc_n;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_bank.sv
// button_bank
//   NUM_BTN independent debounced button channels plus a combined event flag.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   btn       - raw asynchronous button inputs
//   held      - debounced pressed level per channel
//   press     - short-press release pulse per channel
//   long      - long-press threshold pulse per channel
//   rpt       - auto-repeat pulse per channel
//   any_event - OR of press|long|rpt over all channels, one cycle later
module button_bank
  import button_bank_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned ACTIVE_LOW      = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 262144,
  parameter int unsigned LONG_CYCLES     = 67108863,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_CYCLES   = 8388608
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] long,
  output logic [NUM_BTN-1:0] rpt,
  output logic               any_event
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_bank_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[i]),
      .held  (held[i]),
      .press (press[i]),
      .long  (long[i]),
      .rpt   (rpt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) any_event <= 1'b0;
    else     any_event <= |(press | long | rpt);
  end

endmodule

// File: tb/tb_button_bank.sv
module tb_button_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn, btn_nr, btn_al;
  logic [1:0] held, press, long, rpt;
  logic [1:0] held_nr, press_nr, long_nr, rpt_nr;
  logic [1:0] held_al, press_al, long_al, rpt_al;
  logic       any_event, any_nr, any_al;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  button_bank #(.NUM_BTN(2), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4),
                .LONG_CYCLES(16), .REPEAT_EN(1), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .held(held), .press(press),
    .long(long), .rpt(rpt), .any_event(any_event));

  button_bank #(.NUM_BTN(2), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4),
                .LONG_CYCLES(16), .REPEAT_EN(0), .REPEAT_CYCLES(8)) dut_nr (
    .clk(clk), .rst(rst), .btn(btn_nr), .held(held_nr), .press(press_nr),
    .long(long_nr), .rpt(rpt_nr), .any_event(any_nr));

  button_bank #(.NUM_BTN(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
                .LONG_CYCLES(16), .REPEAT_EN(1), .REPEAT_CYCLES(8)) dut_al (
    .clk(clk), .rst(rst), .btn(btn_al), .held(held_al), .press(press_al),
    .long(long_al), .rpt(rpt_al), .any_event(any_al));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn = 2'b00; btn_nr = 2'b00; btn_al = 2'b11;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 2'b11; btn_nr = 2'b00; btn_al = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if ({held, press, long, rpt, any_event} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b want=0", {held, press, long, rpt, any_event});
    end
    vectors++;
    if (dut.g_chan[0].u_chan.sync_q !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_sync_hi got=%b want=00", dut.g_chan[0].u_chan.sync_q);
    end
    vectors++;
    if (dut_al.g_chan[0].u_chan.sync_q !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_sync_al got=%b want=11", dut_al.g_chan[0].u_chan.sync_q);
    end
    vectors++;
    if ({held_al, press_al, long_al, rpt_al, any_al} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs_al got=%b want=0", {held_al, press_al, long_al, rpt_al, any_al});
    end
    idle(0);
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_bounce();
    for (int e = 0; e <= 12; e++) begin
      btn[0] = (e < 3);
      tick();
      vectors++;
      if ({held, press, long} !== 6'b0) begin
        miscompares++;
        $display("FAIL bounce e=%0d got held/press/long=%b want=0", e, {held, press, long});
      end
    end
    idle(4);
  endtask

  task automatic test_short();
    logic exp_held, exp_press, exp_any;
    for (int e = 0; e <= 18; e++) begin
      btn[0] = (e < 10);
      tick();
      exp_held  = (e >= 5 && e < 12);
      exp_press = (e == 12);
      exp_any   = (e == 13);
      vectors++;
      if (held !== {1'b0, exp_held} || press !== {1'b0, exp_press} ||
          long !== 2'b00 || rpt !== 2'b00 || any_event !== exp_any) begin
        miscompares++;
        $display("FAIL short e=%0d got h=%b p=%b l=%b r=%b a=%b want h=%b p=%b l=00 r=00 a=%b",
                 e, held, press, long, rpt, any_event, {1'b0, exp_held}, {1'b0, exp_press}, exp_any);
      end
    end
    idle(4);
  endtask

  task automatic test_long_repeat();
    logic exp_held, exp_long, exp_rpt, exp_any;
    for (int e = 0; e <= 46; e++) begin
      btn[1]    = (e < 40);
      btn_nr[1] = (e < 40);
      tick();
      exp_held = (e >= 5 && e < 42);
      exp_long = (e == 17);
      exp_rpt  = (e == 25 || e == 33 || e == 41);
      exp_any  = (e == 18 || e == 26 || e == 34 || e == 42);
      vectors++;
      if (held !== {exp_held, 1'b0} || long !== {exp_long, 1'b0} ||
          rpt !== {exp_rpt, 1'b0} || press !== 2'b00 || any_event !== exp_any) begin
        miscompares++;
        $display("FAIL long_rpt e=%0d got h=%b l=%b r=%b p=%b a=%b want h=%b l=%b r=%b p=00 a=%b",
                 e, held, long, rpt, press, any_event,
                 {exp_held, 1'b0}, {exp_long, 1'b0}, {exp_rpt, 1'b0}, exp_any);
      end
      vectors++;
      if (held_nr !== {exp_held, 1'b0} || long_nr !== {exp_long, 1'b0} ||
          rpt_nr !== 2'b00 || press_nr !== 2'b00) begin
        miscompares++;
        $display("FAIL no_repeat e=%0d got h=%b l=%b r=%b p=%b want h=%b l=%b r=00 p=00",
                 e, held_nr, long_nr, rpt_nr, press_nr, {exp_held, 1'b0}, {exp_long, 1'b0});
      end
    end
    idle(4);
  endtask

  task automatic test_active_low();
    logic exp_held, exp_press;
    for (int e = 0; e <= 16; e++) begin
      btn_al[0] = !(e < 10);
      tick();
      exp_held  = (e >= 5 && e < 12);
      exp_press = (e == 12);
      vectors++;
      if (held_al !== {1'b0, exp_held} || press_al !== {1'b0, exp_press} ||
          long_al !== 2'b00 || rpt_al !== 2'b00) begin
        miscompares++;
        $display("FAIL active_low e=%0d got h=%b p=%b l=%b r=%b want h=%b p=%b",
                 e, held_al, press_al, long_al, rpt_al, {1'b0, exp_held}, {1'b0, exp_press});
      end
    end
    idle(4);
  endtask

  task automatic test_reset_mid_hold();
    logic exp_held, exp_press;
    for (int e = 0; e <= 26; e++) begin
      btn[0] = (e < 21);
      rst    = (e == 10);
      tick();
      // After reset at edge 10 the synchroniser refills at edges 11/12 and
      // s=1 is sampled at 13..16, so held re-rises after edge 16.
      exp_held  = (e >= 5 && e < 10) || (e >= 16 && e < 23);
      exp_press = (e == 23);
      vectors++;
      if (held !== {1'b0, exp_held} || press !== {1'b0, exp_press} || long !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_mid e=%0d got h=%b p=%b l=%b want h=%b p=%b l=00",
                 e, held, press, long, {1'b0, exp_held}, {1'b0, exp_press});
      end
      if (e == 10) begin
        vectors++;
        if ({held, press, long, rpt, any_event} !== 9'b0) begin
          miscompares++;
          $display("FAIL reset_mid_clear got=%b want=0", {held, press, long, rpt, any_event});
        end
      end
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_concurrent();
    logic exp_held, exp_press, exp_any;
    for (int e = 0; e <= 16; e++) begin
      btn = (e < 10) ? 2'b11 : 2'b00;
      tick();
      exp_held  = (e >= 5 && e < 12);
      exp_press = (e == 12);
      exp_any   = (e == 13);
      vectors++;
      if (held !== {2{exp_held}} || press !== {2{exp_press}} || any_event !== exp_any) begin
        miscompares++;
        $display("FAIL concurrent e=%0d got h=%b p=%b a=%b want h=%b p=%b a=%b",
                 e, held, press, any_event, {2{exp_held}}, {2{exp_press}}, exp_any);
      end
    end
    idle(4);
  endtask

  initial begin
    rst = 1'b1;
    btn = 2'b00; btn_nr = 2'b00; btn_al = 2'b11;
    #1;
    test_reset();
    test_bounce();
    test_short();
    test_long_repeat();
    test_active_low();
    test_reset_mid_hold();
    test_concurrent();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
- Parametrised, multi-channel successor to the single-button conditioner.
- Each of NUM_BTN raw inputs is synchronised and debounced. Each channel produces:
  - a debounced level;
  - a one-cycle short-press pulse on release;
  - a one-cycle long-press pulse at the hold threshold;
  - optional auto-repeat pulses while the button stays held.
- Sits between board pushbuttons and UI/control logic (clock set, mode select).

Parameters:
- NUM_BTN, 4, number of independent button channels (>=1)
- ACTIVE_LOW, 0, 1 = a raw input level of 0 means pressed
- DEBOUNCE_CYCLES, 262144, consecutive synced-pressed samples needed before a press is valid (>=1)
- LONG_CYCLES, 67108863, consecutive synced-pressed samples needed before the long pulse (>DEBOUNCE_CYCLES)
- REPEAT_EN, 1, 1 = emit repeat pulses after a long press
- REPEAT_CYCLES, 8388608, period between repeat pulses (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- btn  in  NUM_BTN  raw asynchronous button inputs
- held  out  NUM_BTN  debounced pressed level, per channel
- press  out  NUM_BTN  one-cycle pulse: short press released
- long  out  NUM_BTN  one-cycle pulse: hold reached LONG_CYCLES
- rpt  out  NUM_BTN  one-cycle pulse: auto-repeat tick
- any_event  out  1  registered OR of press|long|rpt across all channels, delayed one further cycle

Behaviour:
- Channels are fully independent; per-channel behaviour is described below.
- Reset (rst high at an edge): sync flops load the inactive level (ACTIVE_LOW ? 1 : 0), counters go to 0, state goes to IDLE. held, press, long, rpt and any_event are all 0 after that edge.
- Synchroniser: 2 flops. s = sync_q[1] XOR ACTIVE_LOW. Latency from btn to s is 2 edges.
- Timing convention: edge 0 is the first edge sampling btn pressed. s is valid after edge 1.
- Counters:
  - ctr counts consecutive s=1 samples and saturates at LONG_CYCLES; it never wraps.
  - Any s=0 sample clears ctr to 0.
  - Counter width is clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1).
- States: IDLE, DEBOUNCE, HELD, LONG.
  - IDLE -> DEBOUNCE on s=1.
  - DEBOUNCE -> IDLE on s=0, with no pulse (bounce rejected).
  - DEBOUNCE -> HELD when ctr reaches DEBOUNCE_CYCLES; held rises after edge DEBOUNCE_CYCLES+1.
  - HELD -> IDLE on s=0: press=1 for exactly one cycle; held falls on the same edge.
  - HELD -> LONG when ctr reaches LONG_CYCLES: long=1 for one cycle, visible after edge LONG_CYCLES+1; the repeat counter clears.
  - LONG, repeat: if REPEAT_EN, rpt=1 for one cycle every REPEAT_CYCLES, visible after edges LONG_CYCLES+1+k*REPEAT_CYCLES, k>=1. Repeats continue indefinitely with no overflow.
  - LONG -> IDLE on s=0: held falls and press is NOT emitted (a long press suppresses the short press).
- Release latency: btn sampled released at edge t -> s=0 after t+1 -> press/held update after t+2.
- At most one of press/long/rpt is high in any cycle per channel. long and the first rpt never coincide.
- Reset mid-press: all progress is discarded. A button still held after reset needs DEBOUNCE_CYCLES fresh samples before held rises, and the interrupted press emits no press pulse.
- Simultaneous events on different channels are all reported in the same cycle. any_event follows one cycle later.
- All outputs are registered; there are no combinational paths from btn.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/DEBOUNCE/HELD/LONG, 2-bit);
  - a clog2 helper function;
  - the counter-width localparam derivation.
- Sub-module button_bank_chan implements one channel (sync, ctr, repeat counter, FSM, registered outputs).
- The top level is a generate loop of NUM_BTN instances plus the any_event OR/flop.

Test Plan:
All tests use NUM_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=8, ACTIVE_LOW=0 unless stated.
- Bounce: btn[0] high for 3 cycles, then low -> held, press and long stay 0 throughout.
- Short press: btn[0] high for 10 cycles from edge 0 -> held=1 after edge 5; press=1 for one cycle after edge 12; held=0 after edge 12; long never fires.
- Long with repeat: btn[1] held for 40 cycles -> long after edge 17; rpt after edges 25, 33, 41; no press on release; held falls 2 edges after release. Repeat with REPEAT_EN=0 -> no rpt pulses.
- ACTIVE_LOW=1: idle btn=1, press by driving 0 for 10 cycles -> same pulse timing as the short-press case. Under reset, the sync flops hold 1.
- Reset mid-hold: btn[0] held; rst pulsed at edge 10 while btn stays held -> all outputs 0 after edge 10; held re-rises only after 4 more s=1 samples; no press pulse.
- Concurrency: both channels released on the same edge after valid short presses -> press=2'b11 in one cycle; any_event=1 on the following cycle only.
